shift_right_iterative: RTL

- Multi-cycle right shifter supporting logical (SRL) and arithmetic (SRA) shifts of an N-bit word; the right-shift counterpart of the ALU's combinational left shifter.
- Resolves one shamt bit per cycle (shift by 1, 2, 4, 8, 16), trading latency for area instead of using N wide muxes.
- Sits beside the ALU. A valid/ready handshake on input and output lets the multi-cycle controller stall on it.

---
 rtl/shift_right_iterative_pkg.sv | 7 +
 rtl/shift_right_iterative_if.sv | 14 +
 rtl/shift_right_iterative_stage.sv | 16 +
 rtl/shift_right_iterative.sv | 56 +++++
 4 files changed

// File: rtl/shift_right_iterative_pkg.sv
// shifter_pkg: shared types and constants for the iterative right shifter
package shifter_pkg;
  localparam int SHIFT_N = 32;
  localparam int SHIFT_STAGES = 5;
  localparam int SHIFT_CNT_W = 3;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} shift_state_t;
endpackage

// File: rtl/shift_right_iterative_if.sv
// shift_right_iterative_if: request/response handshake bundle for the shifter
interface shift_right_iterative_if;
  import shifter_pkg::*;
  logic i_valid;
  logic i_ready;
  logic [SHIFT_N-1:0] in;
  logic [SHIFT_STAGES-1:0] shamt;
  logic arith;
  logic o_valid;
  logic o_ready;
  logic [SHIFT_N-1:0] out;
  modport master (output i_valid, in, shamt, arith, o_ready, input i_ready, o_valid, out);
  modport slave (input i_valid, in, shamt, arith, o_ready, output i_ready, o_valid, out);
endinterface

// File: rtl/shift_right_iterative_stage.sv
// shift_right_stage: one power-of-two right shift step with selectable fill bit
module shift_right_stage
  import shifter_pkg::*;
(
  input  logic [SHIFT_N-1:0]     data,
  input  logic [SHIFT_CNT_W-1:0] sel,
  input  logic                   en,
  input  logic                   fill,
  output logic [SHIFT_N-1:0]     data_out
);
  logic [SHIFT_STAGES-1:0] amt;
  logic [SHIFT_N-1:0] vacated;
  assign amt = SHIFT_STAGES'(1) << sel;
  assign vacated = ~({SHIFT_N{1'b1}} >> amt);
  assign data_out = en ? (data >> amt) | ({SHIFT_N{fill}} & vacated) : data;
endmodule

// File: rtl/shift_right_iterative.sv
// shift_right_iterative: multi-cycle SRL/SRA resolving one shamt bit per cycle
module shift_right_iterative
  import shifter_pkg::*;
(
  input logic clk,
  input logic rst,
  shift_right_iterative_if.slave bus
);
  localparam logic [SHIFT_CNT_W-1:0] LAST = SHIFT_CNT_W'(SHIFT_STAGES - 1);
  shift_state_t state_q, state_d;
  logic [SHIFT_N-1:0] data_q, data_nx;
  logic [SHIFT_STAGES-1:0] shamt_q;
  logic [SHIFT_CNT_W-1:0] stage_q;
  logic arith_q, sign_q, accept;
  assign accept = bus.i_valid && bus.i_ready;
  shift_right_stage u_stage (
    .data     (data_q),
    .sel      (stage_q),
    .en       (shamt_q[stage_q]),
    .fill     (arith_q & sign_q),
    .data_out (data_nx)
  );
  // state register
  always_ff @(posedge clk)
    state_q <= rst ? IDLE : state_d;
  // next state: accept, walk all stages regardless of shamt, then wait for consumer
  always_comb
    state_d = state_q == IDLE  ? (accept ? SHIFT : IDLE) :
              state_q == SHIFT ? (stage_q == LAST ? DONE : SHIFT) :
                                 (bus.o_ready ? IDLE : DONE);
  // handshake outputs
  always_comb begin
    bus.i_ready = state_q == IDLE && !rst;
    bus.o_valid = state_q == DONE;
  end
  // operand capture on accept, then one stage applied per SHIFT cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      shamt_q <= '0;
      arith_q <= 1'b0;
      sign_q  <= 1'b0;
      stage_q <= '0;
    end else if (accept) begin
      data_q  <= bus.in;
      shamt_q <= bus.shamt;
      arith_q <= bus.arith;
      sign_q  <= bus.in[SHIFT_N-1];
      stage_q <= '0;
    end else if (state_q == SHIFT) begin
      data_q  <= data_nx;
      stage_q <= stage_q + 1'b1;
    end
  end
  assign bus.out = data_q;
endmodule
